// File: rtl/adc_capture_ctrl.sv
// Capture sequencer for the AD9284 sample stream: circular pre-trigger fill,
// level/forced trigger, fixed post-trigger count, then freeze and report addresses.
module adc_capture_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_rising,
  input  logic [ADDR_W-1:0] pretrig_len,
  input  logic              rd_ack,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] ptr, ptr_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic [ADDR_W-1:0] plen, plen_nx;
  logic [ADDR_W-1:0] trig_addr_nx, start_addr_nx;
  logic [ADDR_W-1:0] wr_addr_nx;
  logic [DATA_W-1:0] lvl, lvl_nx;
  logic [DATA_W-1:0] prev, prev_nx;
  logic [DATA_W-1:0] wr_data_nx;
  logic              rising, rising_nx;
  logic              prev_valid, prev_valid_nx;
  logic              pend_force, pend_force_nx;
  logic              wr_en_nx;
  logic              take;
  logic              level_hit;
  logic              hit;
  logic [ADDR_W-1:0] post_len;

  // The write strobe, the counters and the reported addresses all advance on the same edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      plen       <= '0;
      lvl        <= '0;
      rising     <= 1'b0;
      prev       <= '0;
      prev_valid <= 1'b0;
      pend_force <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      trig_addr  <= '0;
      start_addr <= '0;
    end else begin
      state      <= state_nx;
      ptr        <= ptr_nx;
      cnt        <= cnt_nx;
      plen       <= plen_nx;
      lvl        <= lvl_nx;
      rising     <= rising_nx;
      prev       <= prev_nx;
      prev_valid <= prev_valid_nx;
      pend_force <= pend_force_nx;
      wr_en      <= wr_en_nx;
      wr_addr    <= wr_addr_nx;
      wr_data    <= wr_data_nx;
      trig_addr  <= trig_addr_nx;
      start_addr <= start_addr_nx;
    end
  end

  // DEPTH-1-plen is the bitwise complement of plen in ADDR_W bits.
  assign post_len  = ~plen;
  assign take      = s_valid && (state == PRE || state == ARMED || state == POST);
  assign level_hit = rising ? (prev_valid && prev <  lvl && s_data >= lvl)
                            : (prev_valid && prev >= lvl && s_data <  lvl);
  assign hit       = level_hit || pend_force || force_trig;

  always_comb begin
    state_nx      = state;
    ptr_nx        = ptr;
    cnt_nx        = cnt;
    plen_nx       = plen;
    lvl_nx        = lvl;
    rising_nx     = rising;
    prev_nx       = prev;
    prev_valid_nx = prev_valid;
    pend_force_nx = pend_force;
    wr_en_nx      = 1'b0;
    wr_addr_nx    = wr_addr;
    wr_data_nx    = wr_data;
    trig_addr_nx  = trig_addr;
    start_addr_nx = start_addr;

    if (arm) begin
      lvl_nx        = trig_level;
      rising_nx     = trig_rising;
      plen_nx       = pretrig_len;
      ptr_nx        = '0;
      cnt_nx        = '0;
      prev_valid_nx = 1'b0;
      pend_force_nx = 1'b0;
      state_nx      = (pretrig_len == '0) ? ARMED : PRE;
    end else begin
      if (take) begin
        wr_en_nx      = 1'b1;
        wr_addr_nx    = ptr;
        wr_data_nx    = s_data;
        ptr_nx        = ptr + 1'b1;
        prev_nx       = s_data;
        prev_valid_nx = 1'b1;
      end

      unique case (state)
        IDLE: ;
        PRE: begin
          if (force_trig) pend_force_nx = 1'b1;
          if (take) begin
            if (cnt + 1'b1 == plen) begin
              cnt_nx   = '0;
              state_nx = ARMED;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
        end
        ARMED: begin
          if (take && hit) begin
            trig_addr_nx  = ptr;
            start_addr_nx = ptr - plen;
            pend_force_nx = 1'b0;
            cnt_nx        = post_len;
            state_nx      = (post_len == '0) ? DONE : POST;
          end else if (force_trig) begin
            // A force pulse between samples is held so it is not lost.
            pend_force_nx = 1'b1;
          end
        end
        POST: begin
          if (take) begin
            cnt_nx = cnt - 1'b1;
            if (cnt == 1) state_nx = DONE;
          end
        end
        DONE: begin
          if (rd_ack) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign busy    = (state == PRE) || (state == ARMED) || (state == POST);
  assign done    = (state == DONE);
  assign state_o = state;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl (DEPTH=16): directed capture scenarios
// plus randomized traffic against a sample-count based reference model.
module tb_adc_capture_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              rst;
  logic              arm;
  logic              force_trig;
  logic [DATA_W-1:0] trig_level;
  logic              trig_rising;
  logic [ADDR_W-1:0] pretrig_len;
  logic              rd_ack;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] start_addr;
  logic [2:0]        state_o;

  int n_checks;
  int n_fail;
  int wr_count;

  // Reference model: a capture is described by how many samples were written since arm
  // and at which sample index the trigger landed; addresses follow from modular arithmetic.
  int m_active, m_done, m_n, m_trig_n, m_pend, m_prev, m_prev_valid;
  int m_lvl, m_rising, m_plen;
  int m_wr_en, m_wr_addr, m_wr_data, m_trig_addr, m_start_addr;

  adc_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK(clk), .RST(rst), .arm(arm), .force_trig(force_trig),
    .trig_level(trig_level), .trig_rising(trig_rising), .pretrig_len(pretrig_len),
    .rd_ack(rd_ack), .s_valid(s_valid), .s_data(s_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .trig_addr(trig_addr), .start_addr(start_addr),
    .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_n = 0; m_trig_n = -1; m_pend = 0;
    m_prev = 0; m_prev_valid = 0; m_lvl = 0; m_rising = 0; m_plen = 0;
    m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0; m_trig_addr = 0; m_start_addr = 0;
  endtask

  function automatic int exp_state();
    if (m_active == 0)    return 0;
    if (m_done != 0)      return 4;
    if (m_trig_n >= 0)    return 3;
    if (m_n < m_plen)     return 1;
    return 2;
  endfunction

  task automatic model_step(input int a, input int f, input int v, input int d, input int k);
    int  post_len;
    bit  pre, armd, crossing;
    m_wr_en = 0;
    if (a != 0) begin
      m_lvl = int'(trig_level); m_rising = int'(trig_rising); m_plen = int'(pretrig_len);
      m_active = 1; m_done = 0; m_n = 0; m_trig_n = -1; m_pend = 0; m_prev_valid = 0;
    end else if (m_active != 0 && m_done == 0) begin
      post_len = DEPTH - 1 - m_plen;
      pre  = (m_trig_n < 0) && (m_n < m_plen);
      armd = (m_trig_n < 0) && !pre;
      if (pre && f != 0) m_pend = 1;
      if (v != 0) begin
        m_wr_en = 1; m_wr_addr = m_n % DEPTH; m_wr_data = d;
        if (armd) begin
          if (m_rising != 0) crossing = m_prev_valid != 0 && m_prev < m_lvl && d >= m_lvl;
          else               crossing = m_prev_valid != 0 && m_prev >= m_lvl && d < m_lvl;
          if (crossing || m_pend != 0 || f != 0) begin
            m_trig_n     = m_n;
            m_trig_addr  = m_n % DEPTH;
            m_start_addr = ((m_n - m_plen) % DEPTH + DEPTH) % DEPTH;
            m_pend       = 0;
            if (post_len == 0) m_done = 1;
          end
        end else if (!pre) begin
          if (m_n - m_trig_n == post_len) m_done = 1;
        end
        m_prev = d; m_prev_valid = 1; m_n++;
      end else if (armd && f != 0) begin
        m_pend = 1;
      end
    end else if (m_done != 0 && k != 0) begin
      m_active = 0; m_done = 0;
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare on the falling edge.
  task automatic applyStimulus(input bit a, input bit f, input bit v, input logic [7:0] d, input bit k);
    arm = a; force_trig = f; s_valid = v; s_data = d; rd_ack = k;
    model_step(int'(a), int'(f), int'(v), int'(d), int'(k));
    @(posedge clk);
    @(negedge clk);
    arm = 1'b0; force_trig = 1'b0; s_valid = 1'b0; rd_ack = 1'b0;
    if (wr_en === 1'b1) wr_count++;
    checkOutput("wr_en", wr_en, m_wr_en);
    if (m_wr_en != 0) begin
      checkOutput("wr_addr", wr_addr, m_wr_addr);
      checkOutput("wr_data", wr_data, m_wr_data);
    end
    checkOutput("state_o", state_o, exp_state());
    checkOutput("busy", busy, (exp_state() >= 1 && exp_state() <= 3) ? 1 : 0);
    checkOutput("done", done, (exp_state() == 4) ? 1 : 0);
    checkOutput("trig_addr", trig_addr, m_trig_addr);
    checkOutput("start_addr", start_addr, m_start_addr);
  endtask

  task automatic set_cfg(input logic [7:0] lvl, input bit rise, input logic [3:0] plen);
    trig_level = lvl; trig_rising = rise; pretrig_len = plen;
  endtask

  task automatic run_rising(input int gap);
    set_cfg(8'h40, 1'b1, 4'd4);
    applyStimulus(1, 0, 0, 8'h00, 0);
    wr_count = 0;
    for (int n = 0; n < 20; n++) begin
      applyStimulus(0, 0, 1, 8'(8 * n), 0);
      if (n == 8) begin
        checkOutput("rise_trig_addr", trig_addr, 8);
        checkOutput("rise_start_addr", start_addr, 4);
      end
      if (n == 19) begin
        checkOutput("rise_last_addr", wr_addr, 3);
        checkOutput("rise_done_on_last", done & wr_en, 1);
      end
      for (int g = 0; g < gap; g++) applyStimulus(0, 0, 0, 8'($urandom), 0);
    end
    checkOutput("rise_writes", wr_count, 20);
    applyStimulus(0, 0, 0, 8'h00, 1);
    checkOutput("rise_release_idle", state_o, 0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; wr_count = 0;
    rst = 1'b1; arm = 0; force_trig = 0; rd_ack = 0; s_valid = 0; s_data = '0;
    set_cfg(8'h00, 1'b0, 4'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_state", state_o, 0);
    checkOutput("reset_wr_en", wr_en, 0);
    checkOutput("reset_trig_addr", trig_addr, 0);
    rst = 1'b0;

    $display("[TB] rising trigger, continuous and with 3-cycle gaps");
    run_rising(0);
    run_rising(3);

    $display("[TB] forced trigger with no pre-trigger window");
    set_cfg(8'h00, 1'b1, 4'd0);
    applyStimulus(1, 0, 0, 8'h00, 0);
    wr_count = 0;
    applyStimulus(0, 1, 1, 8'h10, 0);
    checkOutput("force_trig_addr", trig_addr, 0);
    checkOutput("force_start_addr", start_addr, 0);
    for (int i = 1; i < 16; i++) applyStimulus(0, 0, 1, 8'h10, 0);
    checkOutput("force_last_addr", wr_addr, 15);
    checkOutput("force_writes", wr_count, 16);
    checkOutput("force_done", done, 1);
    applyStimulus(0, 0, 1, 8'h10, 0);
    checkOutput("force_no_write_in_done", wr_count, 16);

    $display("[TB] falling trigger with crossings in the pre-trigger window");
    set_cfg(8'h80, 1'b0, 4'd6);
    applyStimulus(1, 0, 0, 8'h00, 1);
    checkOutput("arm_beats_ack", state_o, 1);
    for (int n = 0; n < 6; n++) applyStimulus(0, 0, 1, (n % 2 == 0) ? 8'hFF : 8'h00, 0);
    checkOutput("fall_armed", state_o, 2);
    applyStimulus(0, 0, 1, 8'hFF, 0);
    applyStimulus(0, 0, 1, 8'h00, 0);
    checkOutput("fall_post", state_o, 3);
    checkOutput("fall_trig_addr", trig_addr, 7);
    checkOutput("fall_start_addr", start_addr, 1);
    applyStimulus(0, 0, 1, 8'hFF, 0);
    applyStimulus(1, 0, 1, 8'h55, 0);
    checkOutput("arm_in_post_state", state_o, 1);
    applyStimulus(0, 0, 1, 8'h66, 0);
    checkOutput("arm_in_post_ptr", wr_addr, 0);

    $display("[TB] maximum pre-trigger length");
    set_cfg(8'h40, 1'b1, 4'd15);
    applyStimulus(1, 0, 0, 8'h00, 0);
    for (int n = 0; n < 15; n++) applyStimulus(0, 0, 1, 8'h00, 0);
    applyStimulus(0, 1, 1, 8'h01, 0);
    checkOutput("max_pre_done", done, 1);
    checkOutput("max_pre_trig_addr", trig_addr, 15);
    checkOutput("max_pre_start_addr", start_addr, 0);

    $display("[TB] asynchronous reset in the post-trigger phase");
    set_cfg(8'h40, 1'b1, 4'd4);
    applyStimulus(1, 0, 0, 8'h00, 0);
    for (int n = 0; n < 12; n++) applyStimulus(0, 0, 1, 8'(8 * n), 0);
    checkOutput("pre_reset_post", state_o, 3);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_state", state_o, 0);
    checkOutput("async_rst_wr_en", wr_en, 0);
    checkOutput("async_rst_trig", trig_addr, 0);
    checkOutput("async_rst_start", start_addr, 0);
    checkOutput("async_rst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    wr_count = 0;
    for (int n = 0; n < 5; n++) applyStimulus(0, 0, 1, 8'(n), 0);
    checkOutput("no_write_after_rst", wr_count, 0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 4000; c++) begin
      set_cfg(8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom));
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 24) == 0,
                    $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Capture sequencer for the AD9284 sample stream on the ML605. Sits between the deserialised ADC sample bus and a dual-port capture RAM. It arms on command, fills a circular pre-trigger window, detects a level-crossing or forced trigger, records a fixed post-trigger count, then freezes the buffer and reports the window's start and trigger addresses to the readout logic.

## Interface

Parameters:
- DATA_W, 8, sample width
- ADDR_W, 10, capture RAM address width; DEPTH = 2^ADDR_W

Ports:
- CLK  in  1  sample-domain clock; the only clock
- RST  in  1  asynchronous, active-high reset
- arm  in  1  one-cycle pulse; starts or restarts a capture
- force_trig  in  1  one-cycle pulse; forces a trigger
- trig_level  in  DATA_W  unsigned trigger threshold
- trig_rising  in  1  1 = rising-edge trigger, 0 = falling-edge trigger
- pretrig_len  in  ADDR_W  number of samples kept before the trigger sample
- rd_ack  in  1  readout finished; releases DONE
- s_valid  in  1  sample qualifier
- s_data  in  DATA_W  unsigned sample
- wr_en  out  1  capture RAM write strobe
- wr_addr  out  ADDR_W  capture RAM write address
- wr_data  out  DATA_W  capture RAM write data
- busy  out  1  high in PRE, ARMED and POST
- done  out  1  high in DONE
- trig_addr  out  ADDR_W  address of the trigger sample
- start_addr  out  ADDR_W  address of the oldest sample in the window
- state_o  out  3  current state encoding, for the LEDs

## Operation

- States and encodings: IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4.
- arm has priority in every state. On arm:
  - latch trig_level, trig_rising and pretrig_len;
  - set the write pointer to 0;
  - clear prev_valid and pend_force;
  - enter PRE, or ARMED if pretrig_len=0.
- Writes happen only in PRE, ARMED and POST. Each s_valid sample is written at the pointer, then the pointer increments modulo DEPTH. s_valid is ignored in IDLE and DONE.
- PRE: count the samples written. After the pretrig_len-th write, go to ARMED. Triggers are not evaluated in PRE. force_trig in PRE sets pend_force.
- ARMED: keep writing in a circle. A valid sample is the trigger when any of these holds:
  - rising: prev_valid and prev < lvl and cur >= lvl;
  - falling: prev_valid and prev >= lvl and cur < lvl;
  - pend_force is set;
  - force_trig is high in the same cycle.
- On a trigger:
  - the trigger sample is written;
  - trig_addr <= its address;
  - start_addr <= (its address − pretrig_len) mod DEPTH;
  - go to POST with post_cnt = DEPTH−1−pretrig_len, or go straight to DONE if that count is 0.
- prev and prev_valid update on every valid sample in PRE, ARMED and POST.
- POST: each valid sample is written and decrements post_cnt. The write that brings it to 0 moves the block to DONE. Every capture writes exactly pretrig_len+1+post samples past the last pre-trigger overwrite, so the frozen window is the DEPTH contiguous addresses starting at start_addr.
- DONE: hold trig_addr and start_addr. rd_ack moves the block to IDLE. If arm and rd_ack arrive together, arm wins.
- IDLE: outputs idle; trig_addr and start_addr keep their last values.

## Timing

- Reset values: all outputs 0, state IDLE, pointer 0, pend_force 0, prev_valid 0.
- wr_en, wr_addr and wr_data are registered: 1 cycle after the s_valid sample is presented.
- State registers update on the same edge that registers the write. As a result:
  - done rises in the same cycle wr_en is high for the final sample;
  - trig_addr and start_addr are valid in the same cycle wr_en is high for the trigger sample.
- arm takes effect on the next edge. A sample with s_valid high in the arm cycle is not written.
- Gaps in s_valid stall all counters. There is no timeout.
- RST mid-capture aborts immediately. The buffer contents are undefined.

## Test plan

- Reset: assert RST asynchronously mid-POST -> all outputs read 0 and state_o=0 within the same cycle; no wr_en until the next arm.
- Rising trigger (ADDR_W=4, DEPTH=16): pretrig_len=4, trig_level=0x40, trig_rising=1, s_data=8·n with s_valid every cycle -> sample n=8 (0x40) triggers; trig_addr=8; start_addr=4; 20 writes in total; last wr_addr=3; done high on the 20th wr_en.
- Forced trigger (DEPTH=16): pretrig_len=0, force_trig in the cycle after arm, constant data 0x10 -> trigger on the first sample; trig_addr=0; start_addr=0; exactly 16 writes at addresses 0..15; done.
- Falling trigger with crossings during PRE (DEPTH=16): pretrig_len=6, trig_level=0x80, trig_rising=0, data alternating 0xFF/0x00 -> no trigger during the first 6 samples; trigger on sample 7 (0x00), trig_addr=7, start_addr=1.
- Boundaries: pretrig_len=15 -> the trigger sample goes straight to DONE with no POST writes. Arm during POST -> pointer restarts at 0 and state returns to PRE. arm and rd_ack together in DONE -> PRE. s_valid gaps of 3 cycles -> counts and addresses unchanged.
